// File: rtl/matrix_frame_sequencer.sv
// Streams one LED-matrix frame from a frame-buffer read port into output_module, one byte slot
// per tx_finish handshake. Define MATRIX_SEQ_TEST_PATTERN_EN to add the pattern_sel input.
module matrix_frame_sequencer #(
  parameter int unsigned CHANNEL_NUMBER   = 3,
  parameter int unsigned SPI_SIZE         = 8,
  parameter int unsigned COLUMNS          = 8,
  parameter int unsigned BYTES_PER_COLUMN = 48,
  parameter int unsigned FRAME_GAP        = 16,
  parameter int unsigned ACK_TIMEOUT      = 1024,
  localparam int unsigned DATA_W = CHANNEL_NUMBER * SPI_SIZE,
  localparam int unsigned ADDR_W = (COLUMNS * BYTES_PER_COLUMN > 1) ? $clog2(COLUMNS * BYTES_PER_COLUMN) : 1,
  localparam int unsigned COL_W  = (COLUMNS > 1) ? $clog2(COLUMNS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
`ifdef MATRIX_SEQ_TEST_PATTERN_EN
  input  logic [1:0]        pattern_sel,
`endif
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] data_out,
  output logic              new_image,
  output logic              new_column,
  output logic              next_data,
  input  logic              tx_finish,
  output logic [COL_W-1:0]  col_idx,
  output logic              busy,
  output logic              frame_done,
  output logic              err
);

  localparam int unsigned BYTE_W = (BYTES_PER_COLUMN > 1) ? $clog2(BYTES_PER_COLUMN) : 1;
  localparam int unsigned TMO_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned GAP_W  = (FRAME_GAP > 0) ? $clog2(FRAME_GAP + 1) : 1;

  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES_PER_COLUMN - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLUMNS - 1);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(ACK_TIMEOUT);
  localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(FRAME_GAP);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_STROBE, S_WAIT_LOW, S_WAIT_HIGH, S_GAP
  } state_e;

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                rd_en_q, rd_en_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                img_q, img_d;
  logic                colstb_q, colstb_d;
  logic                nxt_q, nxt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                use_fb;
  logic [DATA_W-1:0]   load_data;
  logic                last_slot;

  // Byte source for LOAD: frame buffer, or the built-in test patterns when enabled.
`ifdef MATRIX_SEQ_TEST_PATTERN_EN
  assign use_fb = (pattern_sel == 2'd0);

  always_comb begin
    load_data = rd_data;
    for (int c = 0; c < int'(CHANNEL_NUMBER); c++) begin
      case (pattern_sel)
        2'd1:    load_data[c*SPI_SIZE +: SPI_SIZE] = '1;
        2'd2:    load_data[c*SPI_SIZE +: SPI_SIZE] = SPI_SIZE'(byte_q) ^ SPI_SIZE'(c);
        2'd3:    load_data[c*SPI_SIZE +: SPI_SIZE] = (col_q[0] ^ byte_q[0]) ? '1 : '0;
        default: load_data[c*SPI_SIZE +: SPI_SIZE] = rd_data[c*SPI_SIZE +: SPI_SIZE];
      endcase
    end
  end
`else
  assign use_fb    = 1'b1;
  assign load_data = rd_data;
`endif

  assign last_slot = (col_q == COL_LAST) && (byte_q == BYTE_LAST);

  // Next-state and next-output logic; strobes and pulses default low every cycle.
  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    col_d    = col_q;
    addr_d   = addr_q;
    tmo_d    = tmo_q;
    gap_d    = gap_q;
    rd_en_d  = 1'b0;
    data_d   = data_q;
    img_d    = 1'b0;
    colstb_d = 1'b0;
    nxt_d    = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (run && tx_finish) begin
          state_d = S_FETCH;
          busy_d  = 1'b1;
          rd_en_d = use_fb;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_STROBE;
        data_d  = load_data;
        tmo_d   = '0;
        if (byte_q == '0 && col_q == '0) img_d = 1'b1;
        else if (byte_q == '0)           colstb_d = 1'b1;
        else                             nxt_d = 1'b1;
      end
      S_STROBE: begin
        state_d = S_WAIT_LOW;
        tmo_d   = TMO_W'(1);
      end
      S_WAIT_LOW: begin
        if (!tx_finish) begin
          state_d = S_WAIT_HIGH;
        end else if (tmo_q == TMO_MAX) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          byte_d  = '0;
          col_d   = '0;
          addr_d  = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_WAIT_HIGH: begin
        if (tx_finish) begin
          if (last_slot) begin
            state_d = S_GAP;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            byte_d  = '0;
            col_d   = '0;
            addr_d  = '0;
            gap_d   = '0;
          end else begin
            state_d = S_FETCH;
            rd_en_d = use_fb;
            addr_d  = addr_q + ADDR_W'(1);
            if (byte_q == BYTE_LAST) begin
              byte_d = '0;
              col_d  = col_q + COL_W'(1);
            end else begin
              byte_d = byte_q + BYTE_W'(1);
            end
          end
        end
      end
      // The frame_done cycle opens GAP; FRAME_GAP idle cycles follow before run is sampled.
      S_GAP: begin
        if (gap_q == GAP_MAX) begin
          if (run) begin
            state_d = S_FETCH;
            busy_d  = 1'b1;
            rd_en_d = use_fb;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      byte_q   <= '0;
      col_q    <= '0;
      addr_q   <= '0;
      tmo_q    <= '0;
      gap_q    <= '0;
      rd_en_q  <= 1'b0;
      data_q   <= '0;
      img_q    <= 1'b0;
      colstb_q <= 1'b0;
      nxt_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      byte_q   <= byte_d;
      col_q    <= col_d;
      addr_q   <= addr_d;
      tmo_q    <= tmo_d;
      gap_q    <= gap_d;
      rd_en_q  <= rd_en_d;
      data_q   <= data_d;
      img_q    <= img_d;
      colstb_q <= colstb_d;
      nxt_q    <= nxt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = addr_q;
  assign data_out   = data_q;
  assign new_image  = img_q;
  assign new_column = colstb_q;
  assign next_data  = nxt_q;
  assign col_idx    = col_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_matrix_frame_sequencer.sv
// Randomized bench for matrix_frame_sequencer: a frame-buffer model, an output_module
// responder and an event log checked against slot-level rules of the frame protocol.
module tb_matrix_frame_sequencer;

  localparam int CH    = 3;
  localparam int SPI   = 8;
  localparam int COLS  = 2;
  localparam int BPC   = 3;
  localparam int GAP   = 2;
  localparam int TMO   = 8;
  localparam int SLOTS = COLS * BPC;
  localparam int K_IMG = 0;
  localparam int K_COL = 1;
  localparam int K_DAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic [23:0] rd_data;
  logic [23:0] data_out;
  logic        new_image, new_column, next_data;
  logic        tx_finish = 1'b1;
  logic [0:0]  col_idx;
  logic        busy, frame_done, err;
`ifdef MATRIX_SEQ_TEST_PATTERN_EN
  logic [1:0]  pattern_sel;
`endif

  matrix_frame_sequencer #(
    .CHANNEL_NUMBER(CH), .SPI_SIZE(SPI), .COLUMNS(COLS), .BYTES_PER_COLUMN(BPC),
    .FRAME_GAP(GAP), .ACK_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .run(run),
`ifdef MATRIX_SEQ_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .data_out(data_out),
    .new_image(new_image), .new_column(new_column), .next_data(next_data),
    .tx_finish(tx_finish), .col_idx(col_idx), .busy(busy), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [34:0] outs;
  assign outs = {rd_en, rd_addr, data_out, new_image, new_column, next_data,
                 col_idx, busy, frame_done, err};

  // Frame buffer: one-cycle read latency, garbage on the bus when not read.
  logic [23:0] mem [8];
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 24'($urandom);

  // Event log filled by the monitor.
  int rd_addr_q[$], rd_cyc_q[$], kind_q[$], str_cyc_q[$], str_col_q[$];
  int fd_cyc_q[$], fd_busy_q[$], fd_busy_prev_q[$], rise_q[$], err_cyc_q[$], err_busy_q[$];
  logic [23:0] str_data_q[$];
  int multi_cnt = 0;
  int busy_prev = 0;
  logic err_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en) begin
        rd_addr_q.push_back(int'(rd_addr));
        rd_cyc_q.push_back(cyc);
      end
      if (new_image || new_column || next_data) begin
        if (int'(new_image) + int'(new_column) + int'(next_data) > 1) multi_cnt++;
        kind_q.push_back(new_image ? K_IMG : (new_column ? K_COL : K_DAT));
        str_cyc_q.push_back(cyc);
        str_col_q.push_back(int'(col_idx));
        str_data_q.push_back(data_out);
      end
      if (frame_done) begin
        fd_cyc_q.push_back(cyc);
        fd_busy_q.push_back(int'(busy));
        fd_busy_prev_q.push_back(busy_prev);
      end
      if (err && !err_prev) begin
        err_cyc_q.push_back(cyc);
        err_busy_q.push_back(int'(busy));
      end
    end
    busy_prev = int'(busy);
    err_prev  = err;
  end

  // output_module model: drop tx_finish some cycles after a strobe, raise it later.
  logic resp_en = 1'b0;
  logic resp_rand = 1'b0;
  int drop_cnt = 0, rise_cnt = 0, hold_len = 0;
  always @(negedge clk) begin
    if (!resp_en) begin
      drop_cnt  = 0;
      rise_cnt  = 0;
      tx_finish = 1'b1;
    end else if (new_image || new_column || next_data) begin
      drop_cnt = resp_rand ? int'($urandom_range(4, 1)) : 2;
      hold_len = resp_rand ? int'($urandom_range(6, 1)) : 5;
      rise_cnt = 0;
    end else if (drop_cnt > 0) begin
      drop_cnt--;
      if (drop_cnt == 0) begin
        tx_finish = 1'b0;
        rise_cnt  = hold_len;
      end
    end else if (rise_cnt > 0) begin
      rise_cnt--;
      if (rise_cnt == 0) begin
        tx_finish = 1'b1;
        rise_q.push_back(cyc);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    rd_addr_q.delete(); rd_cyc_q.delete(); kind_q.delete(); str_cyc_q.delete();
    str_col_q.delete(); str_data_q.delete(); fd_cyc_q.delete(); fd_busy_q.delete();
    fd_busy_prev_q.delete(); rise_q.delete(); err_cyc_q.delete(); err_busy_q.delete();
  endtask

  task automatic wait_fd(input int n);
    int k = 0;
    while (fd_cyc_q.size() < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (fd_cyc_q.size() < n) check_eq("wait_frame_done", fd_cyc_q.size(), n);
  endtask

  task automatic wait_strobes(input int n);
    int k = 0;
    while (kind_q.size() < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (kind_q.size() < n) check_eq("wait_strobe", kind_q.size(), n);
  endtask

  // Expected slot sequence derived from slot index arithmetic and handshake timing.
  task automatic check_frames(input int nf, input int t_run);
    int n, slot, exp_kind, exp_fetch, idx;
    n = nf * SLOTS;
    check_eq("strobe_count", kind_q.size(), n);
    check_eq("fetch_count", rd_addr_q.size(), n);
    check_eq("frame_done_count", fd_cyc_q.size(), nf);
    for (int i = 0; i < n && i < kind_q.size() && i < rd_addr_q.size(); i++) begin
      slot     = i % SLOTS;
      exp_kind = (slot == 0) ? K_IMG : (((slot % BPC) == 0) ? K_COL : K_DAT);
      check_eq($sformatf("kind[%0d]", i), kind_q[i], exp_kind);
      check_eq($sformatf("rd_addr[%0d]", i), rd_addr_q[i], slot);
      check_eq($sformatf("data_out[%0d]", i), str_data_q[i], mem[slot]);
      check_eq($sformatf("col_idx[%0d]", i), str_col_q[i], slot / BPC);
      check_eq($sformatf("fetch_to_strobe[%0d]", i), str_cyc_q[i] - rd_cyc_q[i], 2);
      if (i == 0)          exp_fetch = t_run + 1;
      else if (slot == 0)  exp_fetch = (fd_cyc_q.size() >= i / SLOTS) ? fd_cyc_q[i/SLOTS-1] + GAP + 1 : -1;
      else                 exp_fetch = (rise_q.size() >= i) ? rise_q[i-1] + 1 : -1;
      check_eq($sformatf("fetch_cycle[%0d]", i), rd_cyc_q[i], exp_fetch);
    end
    for (int f = 0; f < nf && f < fd_cyc_q.size(); f++) begin
      idx = f * SLOTS + SLOTS - 1;
      check_eq($sformatf("frame_done_cycle[%0d]", f), fd_cyc_q[f],
               (rise_q.size() > idx) ? rise_q[idx] + 1 : -1);
      check_eq($sformatf("busy_at_done[%0d]", f), fd_busy_q[f], 0);
      check_eq($sformatf("busy_before_done[%0d]", f), fd_busy_prev_q[f], 1);
    end
  endtask

  int t_run;

  initial begin
    rst = 1'b1;
    run = 1'b0;
`ifdef MATRIX_SEQ_TEST_PATTERN_EN
    pattern_sel = 2'd0;
`endif
    for (int i = 0; i < 8; i++) mem[i] = 24'($urandom);
    mem[4] = 24'hA53C0F;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", outs, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic frame with fixed handshake timing; slot 4 carries a known word.
    clear_logs();
    resp_rand = 1'b0;
    resp_en   = 1'b1;
    @(negedge clk);
    run = 1'b1;
    t_run = cyc;
    wait_fd(1);
    run = 1'b0;
    repeat (12) @(negedge clk);
    check_frames(1, t_run);
    if (str_data_q.size() > 4) check_eq("data_slot4", str_data_q[4], 24'hA53C0F);

    // Back-to-back frames with random handshake timing; run dropped mid second frame.
    for (int i = 0; i < 8; i++) mem[i] = 24'($urandom);
    clear_logs();
    resp_rand = 1'b1;
    @(negedge clk);
    run = 1'b1;
    t_run = cyc;
    wait_fd(1);
    wait_strobes(SLOTS + 2);
    run = 1'b0;
    wait_fd(2);
    repeat (20) @(negedge clk);
    check_frames(2, t_run);
    if (str_cyc_q.size() > SLOTS && fd_cyc_q.size() > 0)
      check_eq("restart_latency", str_cyc_q[SLOTS] - fd_cyc_q[0], GAP + 3);

    // Ack timeout with tx_finish stuck high.
    clear_logs();
    resp_en = 1'b0;
    repeat (2) @(negedge clk);
    run = 1'b1;
    wait_strobes(1);
    run = 1'b0;
    for (int k = 0; k < 100 && err_cyc_q.size() == 0; k++) @(negedge clk);
    repeat (20) @(negedge clk);
    check_eq("timeout_seen", err_cyc_q.size(), 1);
    if (err_cyc_q.size() > 0 && str_cyc_q.size() > 0) begin
      check_eq("timeout_cycle", err_cyc_q[0] - str_cyc_q[0], TMO + 1);
      check_eq("timeout_busy", err_busy_q[0], 0);
    end
    check_eq("timeout_strobes", kind_q.size(), 1);
    check_eq("timeout_fetches", rd_addr_q.size(), 1);
    check_eq("timeout_no_done", fd_cyc_q.size(), 0);
    check_eq("timeout_err", err, 1);

    // err stays set while a normal frame runs afterwards.
    clear_logs();
    resp_rand = 1'b1;
    resp_en   = 1'b1;
    @(negedge clk);
    run = 1'b1;
    t_run = cyc;
    wait_fd(1);
    run = 1'b0;
    repeat (12) @(negedge clk);
    check_frames(1, t_run);
    check_eq("err_sticky", err, 1);

    // Asynchronous reset while waiting for tx_finish high on the third slot.
    clear_logs();
    resp_rand = 1'b0;
    @(negedge clk);
    run = 1'b1;
    wait_strobes(3);
    repeat (4) @(negedge clk);
    check_eq("pre_reset_busy", busy, 1);
    #1;
    rst = 1'b1;
    resp_en = 1'b0;
    #1;
    check_eq("async_reset_outputs", outs, 0);
    repeat (2) @(negedge clk);
    clear_logs();
    rst = 1'b0;
    resp_en = 1'b1;
    t_run = cyc;
    wait_fd(1);
    run = 1'b0;
    repeat (12) @(negedge clk);
    check_frames(1, t_run);

`ifdef MATRIX_SEQ_TEST_PATTERN_EN
    // Pattern 2: lane c carries byte_idx ^ c and the frame buffer is never read.
    clear_logs();
    pattern_sel = 2'd2;
    @(negedge clk);
    run = 1'b1;
    wait_fd(1);
    run = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("pattern_rd_en", rd_addr_q.size(), 0);
    check_eq("pattern_strobes", kind_q.size(), SLOTS);
    for (int i = 0; i < kind_q.size(); i++) begin
      logic [7:0] b;
      b = 8'(i % BPC);
      check_eq($sformatf("pattern_data[%0d]", i), str_data_q[i], {b ^ 8'd2, b ^ 8'd1, b});
    end
    pattern_sel = 2'd0;
`endif

    check_eq("strobe_exclusive", multi_cnt, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
